pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Upstream neighbour of the 1024x18 program ROM in the RAT MCU.
- Holds the 10-bit program counter, selects the next PC, and drives the ROM address.
- The ROM has a one-cycle synchronous read, so this block also tracks which address the ROM's current output word belongs to.
- Flags words fetched down a discarded path so the control unit never executes them.

Parameters:
- ADDR_W, 10, PC and ROM address width (ROM depth 2^ADDR_W).
- INTR_VEC, 10'h3FF, interrupt vector address loaded when PC_MUX_SEL=2.
- RST_VEC, 10'h000, PC value after reset.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- PC_LD  in  1  load PC from the source chosen by PC_MUX_SEL.
- PC_INC  in  1  increment PC; ignored when PC_LD=1.
- PC_MUX_SEL  in  2  0=FROM_IMMED, 1=FROM_STACK, 2=INTR_VEC, 3=reserved.
- FROM_IMMED  in  ADDR_W  branch/call target from instruction immediate.
- FROM_STACK  in  ADDR_W  return address popped from scratch RAM.
- PC_COUNT  out  ADDR_W  current PC; drives the ROM PROG_ADDR directly (combinational from register).
- IR_ADDR  out  ADDR_W  address whose ROM word is currently on PROG_IR.
- IR_VALID  out  1  PROG_IR holds a committed-path instruction.
- SEL_ERR  out  1  sticky flag: PC_LD seen with PC_MUX_SEL=3.

Behaviour:
- Clock and reset: one clock CLK; RST is synchronous and active-high.
- Reset values: PC_COUNT=RST_VEC, IR_ADDR=RST_VEC, IR_VALID=0, SEL_ERR=0.
- PC update priority per edge: RST > PC_LD > PC_INC > hold.
- PC_LD with sel 0 loads FROM_IMMED; sel 1 loads FROM_STACK; sel 2 loads INTR_VEC.
- PC_LD with sel 3 loads RST_VEC and sets SEL_ERR; SEL_ERR stays set until RST.
- Increment is modulo 2^ADDR_W: 0x3FF+1 -> 0x000, no flag.
- ROM latency tracking: IR_ADDR <= PC_COUNT every non-reset edge, matching the ROM capturing rom[PC_COUNT] on the same edge.
- IR_VALID next value:
  - 0 if RST.
  - 0 in the first cycle after RST deasserts (ROM output not yet fetched from RST_VEC).
  - 0 if PC_LD was 1 this cycle (the word being fetched is the discarded fall-through path).
  - otherwise 1.
- Hold (PC_LD=0, PC_INC=0): PC unchanged; ROM re-reads the same word; IR_VALID stays 1 if already 1.
- Simultaneous PC_LD and PC_INC: load wins; increment discarded.
- Reset mid-operation: RST in any cycle forces reset values at that edge regardless of PC_LD/PC_INC.
- Internal state: a 1-bit "primed" register distinguishes the post-reset bubble. States are BUBBLE (after reset) and RUN; BUBBLE->RUN on the first non-reset edge.
- No combinational path from inputs to PC_COUNT, IR_ADDR or IR_VALID.

Decomposition:
- Shared package rat_pkg:
  - typedef pc_t (logic [ADDR_W-1:0]).
  - enum pc_sel_t {PC_SEL_IMMED=0, PC_SEL_STACK=1, PC_SEL_INTR=2, PC_SEL_RSVD=3}.
  - constants INTR_VEC and RST_VEC.
- One natural sub-module, pc_next_mux: purely combinational next-PC select plus the SEL_ERR set condition.
- The top module holds the PC, IR_ADDR, IR_VALID, primed and SEL_ERR registers.

Test Plan:
- Reset then PC_INC=1 for 4 cycles -> PC_COUNT 0,1,2,3,4; IR_VALID 0,0,1,1,1; IR_ADDR trails PC_COUNT by one cycle.
- PC=0x010, PC_LD=1, sel=0, FROM_IMMED=0x155 -> next PC_COUNT=0x155; IR_VALID=0 for one cycle (IR_ADDR=0x010); then IR_ADDR=0x155 with IR_VALID=1.
- PC=0x3FF, PC_INC=1 -> PC_COUNT=0x000, IR_VALID stays 1.
- PC_LD=1 and PC_INC=1, sel=2 -> PC_COUNT=0x3FF (load wins); then sel=1, FROM_STACK=0x0A2 -> PC_COUNT=0x0A2.
- PC_LD=1, sel=3 at PC=0x020 -> PC_COUNT=0x000, SEL_ERR=1 held across 10 cycles; RST -> SEL_ERR=0.
- RST asserted for one cycle while PC_LD=1, FROM_IMMED=0x200 -> PC_COUNT=0x000, IR_VALID=0 for two cycles, then 1.

Source files
------------

// File: rtl/rat_pkg.sv
// Shared types and fixed addresses for the RAT MCU program-fetch path.
package rat_pkg;

    localparam int ADDR_W = 10;

    typedef logic [ADDR_W-1:0] pc_t;

    typedef enum logic [1:0] {
        PC_SEL_IMMED = 2'd0,
        PC_SEL_STACK = 2'd1,
        PC_SEL_INTR  = 2'd2,
        PC_SEL_RSVD  = 2'd3
    } pc_sel_t;

    localparam pc_t INTR_VEC = 10'h3FF;
    localparam pc_t RST_VEC  = 10'h000;

    // BUBBLE covers the one cycle after reset where the ROM output is stale.
    typedef enum logic {
        FETCH_BUBBLE = 1'b0,
        FETCH_RUN    = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Control-unit <-> fetch-unit signal bundle; master is the control unit side.
interface pc_fetch_unit_if #(
    parameter int ADDR_W = rat_pkg::ADDR_W
);
    logic              PC_LD;
    logic              PC_INC;
    logic [1:0]        PC_MUX_SEL;
    logic [ADDR_W-1:0] FROM_IMMED;
    logic [ADDR_W-1:0] FROM_STACK;
    logic [ADDR_W-1:0] PC_COUNT;
    logic [ADDR_W-1:0] IR_ADDR;
    logic              IR_VALID;
    logic              SEL_ERR;

    modport master (
        output PC_LD, PC_INC, PC_MUX_SEL, FROM_IMMED, FROM_STACK,
        input  PC_COUNT, IR_ADDR, IR_VALID, SEL_ERR
    );

    modport slave (
        input  PC_LD, PC_INC, PC_MUX_SEL, FROM_IMMED, FROM_STACK,
        output PC_COUNT, IR_ADDR, IR_VALID, SEL_ERR
    );
endinterface

// File: rtl/pc_next_mux.sv
// Combinational next-PC selection: load beats increment beats hold.
module pc_next_mux #(
    parameter int                ADDR_W   = rat_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] INTR_VEC = rat_pkg::INTR_VEC,
    parameter logic [ADDR_W-1:0] RST_VEC  = rat_pkg::RST_VEC
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              pc_ld,
    input  logic              pc_inc,
    input  logic [1:0]        pc_mux_sel,
    input  logic [ADDR_W-1:0] from_immed,
    input  logic [ADDR_W-1:0] from_stack,
    output logic [ADDR_W-1:0] pc_next,
    output logic              sel_err_set
);
    import rat_pkg::*;

    logic [ADDR_W-1:0] load_tgt;

    always_comb begin
        load_tgt = RST_VEC;
        case (pc_sel_t'(pc_mux_sel))
            PC_SEL_IMMED: load_tgt = from_immed;
            PC_SEL_STACK: load_tgt = from_stack;
            PC_SEL_INTR:  load_tgt = INTR_VEC;
            // Reserved select falls back to the reset vector and raises the error flag.
            PC_SEL_RSVD:  load_tgt = RST_VEC;
            default:      load_tgt = RST_VEC;
        endcase
    end

    always_comb begin
        pc_next = pc;
        if (pc_ld)
            pc_next = load_tgt;
        else if (pc_inc)
            pc_next = pc + ADDR_W'(1);
    end

    assign sel_err_set = pc_ld && (pc_mux_sel == PC_SEL_RSVD);

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter plus ROM-latency tracking; IR_ADDR/IR_VALID describe the word on PROG_IR.
module pc_fetch_unit #(
    parameter int                ADDR_W   = rat_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] INTR_VEC = rat_pkg::INTR_VEC,
    parameter logic [ADDR_W-1:0] RST_VEC  = rat_pkg::RST_VEC
) (
    input logic              CLK,
    input logic              RST,
    pc_fetch_unit_if.slave   bus
);
    import rat_pkg::*;

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] ir_addr_q;
    logic              ir_valid_q;
    logic              ir_valid_d;
    logic              sel_err_q;
    logic              sel_err_set;
    fetch_state_t      state_q;
    fetch_state_t      state_d;

    pc_next_mux #(
        .ADDR_W   (ADDR_W),
        .INTR_VEC (INTR_VEC),
        .RST_VEC  (RST_VEC)
    ) u_next_mux (
        .pc          (pc_q),
        .pc_ld       (bus.PC_LD),
        .pc_inc      (bus.PC_INC),
        .pc_mux_sel  (bus.PC_MUX_SEL),
        .from_immed  (bus.FROM_IMMED),
        .from_stack  (bus.FROM_STACK),
        .pc_next     (pc_d),
        .sel_err_set (sel_err_set)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= FETCH_BUBBLE;
            pc_q       <= RST_VEC;
            ir_addr_q  <= RST_VEC;
            ir_valid_q <= 1'b0;
            sel_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            // The ROM captures rom[pc_q] on this same edge.
            ir_addr_q  <= pc_q;
            ir_valid_q <= ir_valid_d;
            sel_err_q  <= sel_err_q | sel_err_set;
        end
    end

    // A load means the word being fetched now is the abandoned fall-through.
    always_comb begin
        state_d    = FETCH_RUN;
        ir_valid_d = 1'b0;
        case (state_q)
            FETCH_BUBBLE: begin
                state_d    = FETCH_RUN;
                ir_valid_d = 1'b0;
            end
            FETCH_RUN: begin
                state_d    = FETCH_RUN;
                ir_valid_d = !bus.PC_LD;
            end
            default: begin
                state_d    = FETCH_RUN;
                ir_valid_d = 1'b0;
            end
        endcase
    end

    assign bus.PC_COUNT = pc_q;
    assign bus.IR_ADDR  = ir_addr_q;
    assign bus.IR_VALID = ir_valid_q;
    assign bus.SEL_ERR  = sel_err_q;

    a_rst_clears: assert property (@(posedge CLK)
        RST |=> (!ir_valid_q && pc_q == RST_VEC && !sel_err_q));

    a_ld_squashes: assert property (@(posedge CLK)
        (!RST && bus.PC_LD) |=> !ir_valid_q);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized scoreboard bench for pc_fetch_unit against a cycle-level reference model.
module tb_pc_fetch_unit;

    typedef struct {
        logic [9:0] pc;
        logic [9:0] ir_addr;
        logic       valid;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t sbq[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // reference model state
    int   m_pc    = 0;
    bit   m_err   = 1'b0;
    int   m_edges = 0;

    pc_fetch_unit_if #(.ADDR_W(10)) bus();

    pc_fetch_unit dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, want);
        end
    endtask

    // Drive one cycle of inputs and queue what the outputs must be after the next edge.
    task automatic step(input bit r, input bit ld, input bit inc, input logic [1:0] sel,
                        input logic [9:0] im, input logic [9:0] st);
        exp_t e;
        int   tgt;
        @(negedge clk);
        rst            = r;
        bus.PC_LD      = ld;
        bus.PC_INC     = inc;
        bus.PC_MUX_SEL = sel;
        bus.FROM_IMMED = im;
        bus.FROM_STACK = st;
        if (r) begin
            m_pc    = 0;
            m_err   = 1'b0;
            m_edges = 0;
            e.ir_addr = 10'h000;
            e.valid   = 1'b0;
        end else begin
            e.ir_addr = 10'(m_pc);
            e.valid   = (m_edges > 0) && !ld;
            case (sel)
                2'd0:    tgt = int'(im);
                2'd1:    tgt = int'(st);
                2'd2:    tgt = 'h3FF;
                default: tgt = 0;
            endcase
            if (ld)       m_pc = tgt;
            else if (inc) m_pc = (m_pc + 1) % 1024;
            if (ld && sel == 2'd3) m_err = 1'b1;
            m_edges++;
        end
        e.pc  = 10'(m_pc);
        e.err = m_err;
        sbq.push_back(e);
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 2'd0, 10'h000, 10'h000);
    endtask

    // monitor: every edge with a pending expectation is compared
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("PC_COUNT", bus.PC_COUNT, e.pc);
                check("IR_ADDR",  bus.IR_ADDR,  e.ir_addr);
                check("IR_VALID", 10'(bus.IR_VALID), 10'(e.valid));
                check("SEL_ERR",  10'(bus.SEL_ERR),  10'(e.err));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int waited;
        bus.PC_LD      = 1'b0;
        bus.PC_INC     = 1'b0;
        bus.PC_MUX_SEL = 2'd0;
        bus.FROM_IMMED = '0;
        bus.FROM_STACK = '0;

        step(1, 0, 0, 2'd0, 10'h000, 10'h000);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 2'd0, 10'h000, 10'h000);
        // branch from 0x010 to 0x155
        step(0, 1, 0, 2'd0, 10'h010, 10'h000);
        hold(2);
        step(0, 1, 0, 2'd0, 10'h155, 10'h000);
        hold(2);
        // wrap at the top of the address space
        step(0, 1, 0, 2'd0, 10'h3FF, 10'h000);
        hold(1);
        step(0, 0, 1, 2'd0, 10'h000, 10'h000);
        hold(1);
        // load beats increment; interrupt vector then stack return
        step(0, 1, 1, 2'd2, 10'h000, 10'h000);
        step(0, 1, 0, 2'd1, 10'h000, 10'h0A2);
        hold(1);
        // reserved select: PC to reset vector, sticky error until reset
        step(0, 1, 0, 2'd0, 10'h020, 10'h000);
        hold(1);
        step(0, 1, 0, 2'd3, 10'h000, 10'h000);
        hold(10);
        step(1, 0, 0, 2'd0, 10'h000, 10'h000);
        step(0, 0, 1, 2'd0, 10'h000, 10'h000);
        // reset wins over a concurrent load
        step(1, 1, 0, 2'd0, 10'h200, 10'h000);
        hold(3);

        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 49) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 1) == 1,
                 2'($urandom_range(0, 3)),
                 10'($urandom),
                 10'($urandom));
        end

        waited = 0;
        while (sbq.size() > 0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (sbq.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", sbq.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
